// File: rtl/unified_cache_request_arbiter_pkg.sv
// Shared definitions for the unified cache request arbiter: packet geometry,
// grant source codes, FSM state codes and the one-hot grant vector.
`timescale 1ns/1ps
package unified_cache_request_arbiter_pkg;

    localparam int unsigned UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = 32;
    localparam int unsigned UNIFIED_CACHE_PACKET_VALID_POS     = 31;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_INST   = 2'd1,
        GRANT_DATA   = 2'd2,
        GRANT_REFILL = 2'd3
    } grant_src_e;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic refill;
        logic data;
        logic inst;
    } src_vec_t;

endpackage

// File: rtl/unified_cache_request_arbiter_rr_picker.sv
// Combinational winner selection: refill first unless forced to round-robin,
// then inst/data ordered by rr_ptr. Output is one-hot (or zero).
`timescale 1ns/1ps
module unified_cache_rr_picker
    import unified_cache_request_arbiter_pkg::*;
(
    input  logic     inst_eligible,
    input  logic     data_eligible,
    input  logic     refill_eligible,
    input  logic     rr_ptr,
    input  logic     force_rr,
    output src_vec_t grant_c
);

    always_comb begin
        grant_c = '0;
        if (refill_eligible && !(force_rr && (inst_eligible || data_eligible))) begin
            grant_c.refill = 1'b1;
        end else if (inst_eligible && (!data_eligible || !rr_ptr)) begin
            grant_c.inst = 1'b1;
        end else if (data_eligible) begin
            grant_c.data = 1'b1;
        end
    end

endmodule

// File: rtl/unified_cache_request_arbiter.sv
// Arbitrates inst/data/refill packets onto the single main_ctrl request port.
// Optional refill starvation guard enabled by defining ANTI_STARVATION_EN.
`timescale 1ns/1ps
module unified_cache_request_arbiter
    import unified_cache_request_arbiter_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH_IN_BITS = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`ifdef ANTI_STARVATION_EN
    ,
    parameter int unsigned STARVE_LIMIT     = 4,
    parameter int unsigned STARVE_CNT_WIDTH = 3
`endif
)
(
    input  logic                            clk_in,
    input  logic                            reset_in,
    input  logic [PACKET_WIDTH_IN_BITS-1:0] inst_req_in,
    output logic                            ack_inst_out,
    input  logic [PACKET_WIDTH_IN_BITS-1:0] data_req_in,
    output logic                            ack_data_out,
    input  logic [PACKET_WIDTH_IN_BITS-1:0] refill_req_in,
    output logic                            ack_refill_out,
    output logic [PACKET_WIDTH_IN_BITS-1:0] request_out,
    input  logic                            ack_from_ctrl,
    output logic [1:0]                      grant_src_out
);

    localparam int unsigned VALID_POS = UNIFIED_CACHE_PACKET_VALID_POS;

    arb_state_e state;
    logic       rr_ptr;
    logic       force_rr_c;
    logic       load_c;
    logic       inst_eligible_c;
    logic       data_eligible_c;
    logic       refill_eligible_c;
    src_vec_t   grant_c;

    // A source whose ack is high this cycle still shows its stale, already-taken entry.
    assign inst_eligible_c   = inst_req_in[VALID_POS]   & ~ack_inst_out;
    assign data_eligible_c   = data_req_in[VALID_POS]   & ~ack_data_out;
    assign refill_eligible_c = refill_req_in[VALID_POS] & ~ack_refill_out;

    assign load_c = (state == STATE_IDLE) | ack_from_ctrl;

    unified_cache_rr_picker u_picker (
        .inst_eligible   (inst_eligible_c),
        .data_eligible   (data_eligible_c),
        .refill_eligible (refill_eligible_c),
        .rr_ptr          (rr_ptr),
        .force_rr        (force_rr_c),
        .grant_c         (grant_c)
    );

`ifdef ANTI_STARVATION_EN
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

    assign force_rr_c = (starve_cnt == STARVE_CNT_WIDTH'(STARVE_LIMIT));

    // Counts refill wins over waiting inst/data; saturates at the limit.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            starve_cnt <= '0;
        end else if (load_c) begin
            if (grant_c.inst || grant_c.data) begin
                starve_cnt <= '0;
            end else if (grant_c.refill && (inst_eligible_c || data_eligible_c) && !force_rr_c) begin
                starve_cnt <= starve_cnt + STARVE_CNT_WIDTH'(1);
            end
        end
    end
`else
    assign force_rr_c = 1'b0;
`endif

    // Request holding register, ack pulses and round-robin pointer.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state          <= STATE_IDLE;
            request_out    <= '0;
            grant_src_out  <= GRANT_NONE;
            ack_inst_out   <= 1'b0;
            ack_data_out   <= 1'b0;
            ack_refill_out <= 1'b0;
            rr_ptr         <= 1'b0;
        end else begin
            ack_inst_out   <= 1'b0;
            ack_data_out   <= 1'b0;
            ack_refill_out <= 1'b0;
            if (load_c) begin
                if (grant_c.refill) begin
                    request_out    <= refill_req_in;
                    grant_src_out  <= GRANT_REFILL;
                    ack_refill_out <= 1'b1;
                    state          <= STATE_HOLD;
                end else if (grant_c.inst) begin
                    request_out    <= inst_req_in;
                    grant_src_out  <= GRANT_INST;
                    ack_inst_out   <= 1'b1;
                    rr_ptr         <= 1'b1;
                    state          <= STATE_HOLD;
                end else if (grant_c.data) begin
                    request_out    <= data_req_in;
                    grant_src_out  <= GRANT_DATA;
                    ack_data_out   <= 1'b1;
                    rr_ptr         <= 1'b0;
                    state          <= STATE_HOLD;
                end else begin
                    request_out    <= '0;
                    grant_src_out  <= GRANT_NONE;
                    state          <= STATE_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_cache_request_arbiter.sv
// Self-checking bench for unified_cache_request_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_unified_cache_request_arbiter;
    import unified_cache_request_arbiter_pkg::*;

    localparam int unsigned PW    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int unsigned VP    = UNIFIED_CACHE_PACKET_VALID_POS;
    localparam int          LIMIT = 4;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [PW-1:0] inst_req_in, data_req_in, refill_req_in;
    logic          ack_inst_out, ack_data_out, ack_refill_out;
    logic [PW-1:0] request_out;
    logic          ack_from_ctrl;
    logic [1:0]    grant_src_out;

    always #5 clk_in = ~clk_in;

    unified_cache_request_arbiter dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .inst_req_in    (inst_req_in),
        .ack_inst_out   (ack_inst_out),
        .data_req_in    (data_req_in),
        .ack_data_out   (ack_data_out),
        .refill_req_in  (refill_req_in),
        .ack_refill_out (ack_refill_out),
        .request_out    (request_out),
        .ack_from_ctrl  (ack_from_ctrl),
        .grant_src_out  (grant_src_out)
    );

    // Source FIFOs; the head is presented until the source sees its ack.
    logic [PW-1:0] q_inst[$], q_data[$], q_refill[$];
    logic [2:0]    pend_pop;

    // Reference model: what main_ctrl sees and which source was told to pop.
    logic [PW-1:0] m_req;
    int            m_src;
    bit            m_data_first;
    int            m_starve;
    logic [2:0]    m_ack;

    int n_cmp, n_bad, cyc;
    int ctrl_mode, ctrl_pct;
    int g_log[$], g_cyc[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [PW-1:0] new_pkt();
        logic [PW-1:0] p;
        p = PW'($urandom);
        p[VP] = 1'b1;
        return p;
    endfunction

    function automatic void model_reset();
        m_req = '0; m_src = 0; m_data_first = 0; m_starve = 0; m_ack = '0;
    endfunction

    function automatic void model_step();
        bit ei, ed, er, any_id, take_refill;
        int w;
        ei = inst_req_in[VP]   && !m_ack[0];
        ed = data_req_in[VP]   && !m_ack[1];
        er = refill_req_in[VP] && !m_ack[2];
        if (m_src != 0 && !ack_from_ctrl) begin
            m_ack = '0;
            return;
        end
        any_id      = ei || ed;
        take_refill = er;
`ifdef ANTI_STARVATION_EN
        if (m_starve == LIMIT && any_id) take_refill = 0;
`endif
        if (take_refill)   w = 3;
        else if (ei && ed) w = m_data_first ? 2 : 1;
        else if (ei)       w = 1;
        else if (ed)       w = 2;
        else               w = 0;
`ifdef ANTI_STARVATION_EN
        if (w == 3 && any_id && m_starve < LIMIT) m_starve++;
        else if (w == 1 || w == 2) m_starve = 0;
`endif
        if (w == 1) m_data_first = 1;
        if (w == 2) m_data_first = 0;
        m_src = w;
        case (w)
            1:       m_req = inst_req_in;
            2:       m_req = data_req_in;
            3:       m_req = refill_req_in;
            default: m_req = '0;
        endcase
        m_ack = (w == 0) ? 3'b000 : 3'(1 << (w - 1));
    endfunction

    function automatic void compare_all();
        check("request_out",    64'(request_out),    64'(m_req));
        check("grant_src_out",  64'(grant_src_out),  64'(m_src));
        check("ack_inst_out",   64'(ack_inst_out),   64'(m_ack[0]));
        check("ack_data_out",   64'(ack_data_out),   64'(m_ack[1]));
        check("ack_refill_out", 64'(ack_refill_out), 64'(m_ack[2]));
        if (ack_inst_out || ack_data_out || ack_refill_out) begin
            g_log.push_back(int'(grant_src_out));
            g_cyc.push_back(cyc);
        end
    endfunction

    // Called at a negedge: apply pops, drive inputs, advance model, check next cycle.
    task automatic tick();
        if (pend_pop[0] && q_inst.size()   > 0) void'(q_inst.pop_front());
        if (pend_pop[1] && q_data.size()   > 0) void'(q_data.pop_front());
        if (pend_pop[2] && q_refill.size() > 0) void'(q_refill.pop_front());
        pend_pop      = {ack_refill_out, ack_data_out, ack_inst_out};
        inst_req_in   = (q_inst.size()   > 0) ? q_inst[0]   : '0;
        data_req_in   = (q_data.size()   > 0) ? q_data[0]   : '0;
        refill_req_in = (q_refill.size() > 0) ? q_refill[0] : '0;
        case (ctrl_mode)
            1:       ack_from_ctrl = 1'b1;
            2:       ack_from_ctrl = (m_src != 0) && (m_ack == 3'b000);
            3:       ack_from_ctrl = 1'b0;
            default: ack_from_ctrl = ($urandom_range(0, 99) < ctrl_pct);
        endcase
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        compare_all();
    endtask

    task automatic clear_sources();
        q_inst.delete(); q_data.delete(); q_refill.delete();
        pend_pop = '0;
        inst_req_in = '0; data_req_in = '0; refill_req_in = '0;
        ack_from_ctrl = 1'b0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        clear_sources();
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        check("reset_request", 64'(request_out), 64'd0);
        check("reset_grant",   64'(grant_src_out), 64'd0);
        check("reset_acks",    64'({ack_inst_out, ack_data_out, ack_refill_out}), 64'd0);
        reset_in = 1'b0;
        g_log.delete(); g_cyc.delete();
    endtask

    initial begin
        int acks_seen;
        int exp5[6];
        logic [PW-1:0] held;
        n_cmp = 0; n_bad = 0; cyc = 0;
        ctrl_mode = 1; ctrl_pct = 60;
        @(negedge clk_in);
        do_reset();

        // Ack while idle with no sources: nothing moves.
        ctrl_mode = 1;
        repeat (4) tick();
        check("idle_ack_grant",   64'(grant_src_out), 64'd0);
        check("idle_ack_request", 64'(request_out),   64'd0);

        // Inst+data alternate with ctrl acking every cycle, no bubbles.
        do_reset();
        repeat (4) begin q_inst.push_back(new_pkt()); q_data.push_back(new_pkt()); end
        ctrl_mode = 1;
        repeat (10) tick();
        check("rr_count", 64'(g_log.size() >= 4), 64'd1);
        if (g_log.size() >= 4) begin
            check("rr_g0", 64'(g_log[0]), 64'd1);
            check("rr_g1", 64'(g_log[1]), 64'd2);
            check("rr_g2", 64'(g_log[2]), 64'd1);
            check("rr_g3", 64'(g_log[3]), 64'd2);
            check("rr_no_bubble", 64'(g_cyc[3] - g_cyc[0]), 64'd3);
        end

        // Refill wins first, then inst, then data.
        do_reset();
        q_refill.push_back(new_pkt());
        repeat (2) begin q_inst.push_back(new_pkt()); q_data.push_back(new_pkt()); end
        ctrl_mode = 1;
        repeat (3) tick();
        check("prio_count", 64'(g_log.size()), 64'd3);
        if (g_log.size() >= 3) begin
            check("prio_g0", 64'(g_log[0]), 64'd3);
            check("prio_g1", 64'(g_log[1]), 64'd1);
            check("prio_g2", 64'(g_log[2]), 64'd2);
        end

        // Ctrl withholds ack: stable request, single ack pulse.
        do_reset();
        q_inst.push_back(new_pkt()); q_inst.push_back(new_pkt());
        held = q_inst[0];
        ctrl_mode = 3;
        acks_seen = 0;
        repeat (6) begin
            tick();
            if (ack_inst_out) acks_seen++;
        end
        check("hold_request", 64'(request_out), 64'(held));
        check("hold_grant",   64'(grant_src_out), 64'd1);
        check("hold_ack_pulses", 64'(acks_seen), 64'd1);
        ctrl_mode = 1;
        repeat (4) tick();

        // Stale entry in the ack cycle is not re-granted.
        do_reset();
        q_inst.push_back(new_pkt());
        ctrl_mode = 1;
        tick();
        check("stale_first", 64'(grant_src_out), 64'd1);
        tick();
        check("stale_regrant", 64'(grant_src_out), 64'd0);

        // Async reset mid-HOLD drops the held inst packet.
        do_reset();
        q_inst.push_back(new_pkt());
        ctrl_mode = 3;
        repeat (3) tick();
        check("pre_reset_grant", 64'(grant_src_out), 64'd1);
        #2 reset_in = 1'b1;
        #1;
        check("async_reset_request", 64'(request_out), 64'd0);
        check("async_reset_grant",   64'(grant_src_out), 64'd0);
        clear_sources();
        model_reset();
        @(negedge clk_in);
        reset_in = 1'b0;
        acks_seen = 0;
        repeat (3) begin
            tick();
            if (ack_inst_out || ack_data_out || ack_refill_out) acks_seen++;
        end
        check("post_reset_acks", 64'(acks_seen), 64'd0);

        // Refill saturating the port while data waits.
        do_reset();
        ctrl_mode = 2;
`ifdef ANTI_STARVATION_EN
        exp5 = '{3, 3, 3, 3, 2, 3};
`else
        exp5 = '{3, 3, 3, 3, 3, 3};
`endif
        for (int i = 0; i < 80 && g_log.size() < 6; i++) begin
            while (q_refill.size() < 2) q_refill.push_back(new_pkt());
            while (q_data.size()   < 2) q_data.push_back(new_pkt());
            tick();
        end
        check("starve_count", 64'(g_log.size() >= 6), 64'd1);
        if (g_log.size() >= 6)
            for (int i = 0; i < 6; i++) check($sformatf("starve_g%0d", i), 64'(g_log[i]), 64'(exp5[i]));

        // Randomized traffic with random ctrl back-pressure.
        do_reset();
        ctrl_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) ctrl_pct = $urandom_range(20, 100);
            if (q_inst.size()   < 4 && $urandom_range(0, 99) < 35) q_inst.push_back(new_pkt());
            if (q_data.size()   < 4 && $urandom_range(0, 99) < 35) q_data.push_back(new_pkt());
            if (q_refill.size() < 4 && $urandom_range(0, 99) < 25) q_refill.push_back(new_pkt());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
